// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, width helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 12 MHz system clock / 230400 baud used by the LD19 lidar link
    localparam int CLK_DIV_LD19 = 52;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Bits needed to hold 0..value-1, never less than 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous serial line.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    // Both flops come out of reset at the idle level so no false start edge is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with glitch-rejecting start, parity/framing checks and
// a valid/ready holding register. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_LD19,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_frame_err,
    output logic                 out_parity_err,
    output logic                 out_overrun,
    output logic                 busy
);

    localparam int CNT_W = clog2(CLK_DIV);
    localparam int IDX_W = clog2(DATA_BITS);
    localparam int HALF  = CLK_DIV / 2;

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic rx_s;
    logic rx_t;    // level used for edge/idle detection
    logic rx_bit;  // value taken at a sample point

    uart_rx_sync u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    // The whole bit timeline runs one cycle behind rx_s, so at each sample tick
    // rx_d2/rx_d1/rx_s are the values at target-1/target/target+1.
    assign rx_t   = rx_d1;
    assign rx_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign rx_t   = rx_s;
    assign rx_bit = rx_s;
`endif

    rx_state_t            state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par_err, par_err_d;
    logic                 frm_err, frm_err_d;
    logic                 post;
    logic                 tick;

    assign tick = (cnt == BIT_END);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
            par_err <= par_err_d;
            frm_err <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        idx_d     = idx;
        shreg_d   = shreg;
        par_err_d = par_err;
        frm_err_d = frm_err;
        post      = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_t) state_d = START;
            end

            // Start bit is re-checked at its centre; a high level there was a glitch
            START: begin
                if (cnt == HALF_END) begin
                    cnt_d     = '0;
                    idx_d     = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    state_d   = rx_bit ? IDLE : DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rx_bit, shreg[DATA_BITS-1:1]};
                    if (idx == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end

            uart_pkg::PARITY: begin
                if (tick) begin
                    cnt_d     = '0;
                    par_err_d = ((^shreg) ^ rx_bit) != (PARITY == PAR_ODD);
                    state_d   = STOP;
                end
            end

            // A low final stop bit means break or misframing: wait for the line to
            // go high so a held-low line cannot produce a stream of words.
            STOP: begin
                if (tick) begin
                    cnt_d     = '0;
                    frm_err_d = frm_err | ~rx_bit;
                    if (idx == LAST_STOP) begin
                        post    = 1'b1;
                        idx_d   = '0;
                        state_d = rx_bit ? IDLE : WAIT_HIGH;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_t) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Holding register: a new word always wins, even over an unaccepted one
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_frame_err  <= 1'b0;
            out_parity_err <= 1'b0;
            out_overrun    <= 1'b0;
        end else if (post) begin
            out_valid      <= 1'b1;
            out_data       <= shreg;
            out_frame_err  <= frm_err_d;
            out_parity_err <= par_err;
            out_overrun    <= out_valid && !out_ready;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receiver, successor to the fixed 12 MHz / 230400 baud LD19 receiver.
- Generic clocks-per-bit, data width and parity mode.
- Proper start-glitch rejection, stop-bit framing check and parity check.
- Valid/ready output holding register with overrun reporting. Sits between the LD19 UART pin and the packet decoder / error statistics logic.

Parameters:
- CLK_DIV, 52, clk cycles per bit (12 MHz / 230400); legal range 8..65535.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, checked stop bits; legal values 1..2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx  in  1  asynchronous serial line, idle high.
- out_data  out  DATA_BITS  received word.
- out_valid  out  1  out_data and flags valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_frame_err  out  1  stop bit sampled low for this word.
- out_parity_err  out  1  parity mismatch for this word (0 when PARITY=0).
- out_overrun  out  1  previous unaccepted word was overwritten by this one.
- busy  out  1  FSM not in IDLE.

Behaviour:
- **Reset:** out_valid, all flags, busy and out_data are 0. FSM goes to IDLE, counters cleared, synchroniser loaded with 1. Reset mid-frame discards the frame with no output.
- **Synchroniser:** rx passes through a 2-flop synchroniser to give rx_s; all sampling uses rx_s. HALF = CLK_DIV/2, truncated.
- **Bit counter:** cnt has width $clog2(CLK_DIV); a bit is sampled when cnt == CLK_DIV-1, then cnt returns to 0.
- **IDLE:** rx_s == 0 → START, cnt = 0.
- **START:** at cnt == HALF-1, sample rx_s.
  - 1 → IDLE (glitch, no output).
  - 0 → DATA, cnt = 0, bit_idx = 0.
- **DATA:** each sample shifts in LSB first. After the DATA_BITS-th sample → PARITY if PARITY != 0, else STOP.
- **PARITY:** one sample; parity_err = (XOR of data bits ^ sampled bit) != (PARITY == 2). Then → STOP.
- **STOP:** STOP_BITS samples; frame_err is set if any sample is 0.
  - After the last sample, the word is posted in the same cycle.
  - Next state is IDLE if the last stop sample is 1, else WAIT_HIGH.
- **WAIT_HIGH (break/framing recovery):** stay until rx_s == 1, then IDLE. A line held low never generates repeated words.
- **Post:** in the cycle after the final stop sample, out_valid = 1 and out_data and the flags are updated.
  - If out_valid was already 1 and not accepted that cycle, the old word is overwritten and out_overrun = 1.
  - Otherwise out_overrun = 0.
- **Handshake:**
  - out_valid clears on the cycle after out_valid && out_ready.
  - Acceptance and a new post in the same cycle: the new word wins, out_valid stays 1, out_overrun = 0.
  - Outputs are stable while out_valid && !out_ready.
- **Receiver is never back-pressured:** reception always continues. Mid-stop-bit return to IDLE gives half a bit of margin for the next start edge.
- **Latency:** out_valid rises 2 + HALF + (DATA_BITS + (PARITY != 0) + STOP_BITS) * CLK_DIV + 1 cycles (±1) after the rx falling edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- **Defined:** every sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s at cnt = target-1, target and target+1.
  - The decision is taken at target+1, so the bit period is unchanged.
  - Requires CLK_DIV >= 8.
- **Undefined:** single sample at target. Word-level behaviour is identical on a clean line.

Decomposition:
- **Package uart_pkg:**
  - parity mode localparams PAR_NONE / PAR_EVEN / PAR_ODD.
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - function clog2.
  - default CLK_DIV_LD19 = 52.
- **Sub-module uart_rx_sync:** 2-flop synchroniser with reset value 1. Shared with the future TX loopback checker.
- Everything else stays in uart_rx_frame.

Test Plan:
- **Basic frame:** CLK_DIV=52, 8N1, frame 0xA5 → out_data = 0xA5, out_valid after 497±1 cycles, no flags set; out_ready=1 clears out_valid the next cycle.
- **Start glitch:** rx low for 20 cycles then high → no out_valid, busy returns to 0, a following 0x3C frame is received correctly.
- **Parity:**
  - PARITY=1 frame 0x07 with parity bit 1 → parity_err = 0.
  - Same frame with parity bit 0 → out_parity_err = 1, out_data = 0x07.
- **Framing error / break:** frame 0x55 with stop bit 0, then rx held low 2000 cycles → one word with out_frame_err = 1, no further words; after rx returns high, 0x81 is received cleanly.
- **Overrun:** out_ready=0, frames 0x11 then 0x22 → out_data = 0x22, out_overrun = 1. Then out_ready=1 on the cycle of the next post (0x33) → out_overrun = 0, out_valid stays 1.
- **Reset mid-frame:** assert reset during data bit 4 of 0xFF → outputs 0, no word posted; next frame 0x42 is received correctly. Repeat with UART_RX_MAJORITY_EN and a 1-cycle glitch at each sample point → data unaffected.
